// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I control FSM over a shared memory port.
// Optional ILLEGAL_TRAP_EN: illegal opcodes trap to ERROR instead of acting as NOP.
module multicycle_sequencer #(
   parameter int CNT_W      = 32,
   parameter int WAIT_LIMIT = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             i_or_d,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_src,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic             reg_write,
   output logic             mem_to_reg,
   output logic [2:0]       state,
   output logic             retire,
   output logic [CNT_W-1:0] instret,
   output logic             mem_err,
   output logic             illegal_trap
);

   localparam logic [2:0] FETCH  = 3'd0;
   localparam logic [2:0] DECODE = 3'd1;
   localparam logic [2:0] EXEC   = 3'd2;
   localparam logic [2:0] MEM    = 3'd3;
   localparam logic [2:0] WB     = 3'd4;
   localparam logic [2:0] ERROR  = 3'd5;

   localparam logic [2:0] C_R   = 3'd0;
   localparam logic [2:0] C_I   = 3'd1;
   localparam logic [2:0] C_LW  = 3'd2;
   localparam logic [2:0] C_SW  = 3'd3;
   localparam logic [2:0] C_BEQ = 3'd4;
   localparam logic [2:0] C_ILL = 3'd5;

   localparam logic [7:0] LIM = 8'(WAIT_LIMIT - 1);

   logic [2:0]       state_q;
   logic [2:0]       nxt;
   logic [2:0]       cls_q;
   logic [2:0]       cls_d;
   logic [7:0]       wait_q;
   logic [CNT_W-1:0] instret_q;
   logic             mem_err_q;
   logic             timeout;

   always_comb begin
      cls_d = C_ILL;
      unique case (1'b1)
         opcode == 7'b0110011: cls_d = C_R;
         opcode == 7'b0010011: cls_d = C_I;
         opcode == 7'b0000011: cls_d = C_LW;
         opcode == 7'b0100011: cls_d = C_SW;
         opcode == 7'b1100011: cls_d = C_BEQ;
         default:              cls_d = C_ILL;
      endcase
   end

   // Every control output is a decode of state_q/cls_q, zeroed under reset.
   always_comb begin
      nxt        = state_q;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      i_or_d     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      retire     = 1'b0;
      timeout    = 1'b0;
      if (reset) begin
         case (state_q)
            FETCH: begin
               mem_req   = 1'b1;
               alu_src_b = 2'b01;
               if (mem_ready) begin
                  ir_write = 1'b1;
                  pc_write = 1'b1;
                  nxt      = DECODE;
               end
            end
            DECODE: begin
               alu_src_a = 2'b10;
               alu_src_b = 2'b10;
               if (cls_d != C_ILL) begin
                  nxt = EXEC;
               end else begin
`ifdef ILLEGAL_TRAP_EN
                  nxt = ERROR;
`else
                  retire = 1'b1;
                  nxt    = FETCH;
`endif
               end
            end
            EXEC: begin
               alu_src_a = 2'b01;
               case (cls_q)
                  C_R: begin
                     alu_op = 2'b10;
                     nxt    = WB;
                  end
                  C_I: begin
                     alu_src_b = 2'b10;
                     alu_op    = 2'b10;
                     nxt       = WB;
                  end
                  C_LW, C_SW: begin
                     alu_src_b = 2'b10;
                     nxt       = MEM;
                  end
                  C_BEQ: begin
                     alu_op   = 2'b01;
                     pc_src   = 1'b1;
                     pc_write = zero;
                     retire   = 1'b1;
                     nxt      = FETCH;
                  end
                  default: nxt = FETCH;
               endcase
            end
            MEM: begin
               mem_req = 1'b1;
               i_or_d  = 1'b1;
               mem_we  = (cls_q == C_SW);
               if (mem_ready) begin
                  if (cls_q == C_SW) begin
                     retire = 1'b1;
                     nxt    = FETCH;
                  end else begin
                     nxt = WB;
                  end
               end
            end
            WB: begin
               reg_write  = 1'b1;
               mem_to_reg = (cls_q == C_LW);
               retire     = 1'b1;
               nxt        = FETCH;
            end
            ERROR:   nxt = ERROR;
            default: nxt = FETCH;
         endcase
         timeout = mem_req && !mem_ready && (wait_q == LIM);
         if (timeout) nxt = ERROR;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= FETCH;
         cls_q     <= C_R;
         wait_q    <= 8'd0;
         instret_q <= '0;
         mem_err_q <= 1'b0;
      end else begin
         state_q <= nxt;
         if (state_q == DECODE) cls_q <= cls_d;
         if (mem_req && mem_ready) wait_q <= 8'd0;
         else if (mem_req) wait_q <= wait_q + 8'd1;
         instret_q <= instret_q + {{(CNT_W-1){1'b0}}, retire};
         if (timeout) mem_err_q <= 1'b1;
      end
   end

`ifdef ILLEGAL_TRAP_EN
   logic trap_q;

   always_ff @(posedge clk) begin
      if (!reset) trap_q <= 1'b0;
      else if (state_q == DECODE && cls_d == C_ILL) trap_q <= 1'b1;
   end

   assign illegal_trap = trap_q;
`else
   assign illegal_trap = 1'b0;
`endif

   assign state   = state_q;
   assign instret = instret_q;
   assign mem_err = mem_err_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed scoreboard bench for multicycle_sequencer.
// Also builds with ILLEGAL_TRAP_EN to check the illegal-opcode trap.
module tb_multicycle_sequencer;

   localparam logic [1:0] A_PC = 2'b00, A_RS1 = 2'b01, A_OLD = 2'b10;
   localparam logic [1:0] B_RS2 = 2'b00, B_4 = 2'b01, B_IMM = 2'b10;
   localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_FN = 2'b10;
   localparam logic [6:0] OPC_R = 7'b0110011, OPC_I = 7'b0010011;
   localparam logic [6:0] OPC_LW = 7'b0000011, OPC_SW = 7'b0100011;
   localparam logic [6:0] OPC_BEQ = 7'b1100011, OPC_ILL = 7'b1111111;

   logic clk = 1'b0;
   logic reset, zero, mem_ready;
   logic [6:0] opcode;

   logic a_req, a_we, a_iod, a_irw, a_pcw, a_pcs, a_rw, a_m2r, a_ret;
   logic a_err, a_trap;
   logic [1:0] a_sa, a_sb, a_op;
   logic [2:0] a_state;
   logic [3:0] a_instret;

   logic b_req, b_we, b_iod, b_irw, b_pcw, b_pcs, b_rw, b_m2r, b_ret;
   logic b_err, b_trap;
   logic [1:0] b_sa, b_sb, b_op;
   logic [2:0] b_state;
   logic [31:0] b_instret;

   logic [14:0] a_ctl, b_ctl;
   assign a_ctl = {a_req, a_we, a_iod, a_irw, a_pcw, a_pcs,
                   a_sa, a_sb, a_op, a_rw, a_m2r, a_ret};
   assign b_ctl = {b_req, b_we, b_iod, b_irw, b_pcw, b_pcs,
                   b_sa, b_sb, b_op, b_rw, b_m2r, b_ret};

   int n_cmp = 0;
   int n_bad = 0;
   logic [3:0] exp_cnt;
   logic [3:0] sb[$];

   always #5 clk = ~clk;

   multicycle_sequencer #(.CNT_W(4), .WAIT_LIMIT(15)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .mem_req(a_req), .mem_we(a_we),
      .i_or_d(a_iod), .ir_write(a_irw), .pc_write(a_pcw),
      .pc_src(a_pcs), .alu_src_a(a_sa), .alu_src_b(a_sb),
      .alu_op(a_op), .reg_write(a_rw), .mem_to_reg(a_m2r),
      .state(a_state), .retire(a_ret), .instret(a_instret),
      .mem_err(a_err), .illegal_trap(a_trap)
   );

   multicycle_sequencer #(.CNT_W(32), .WAIT_LIMIT(3)) dut_t (
      .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .mem_req(b_req), .mem_we(b_we),
      .i_or_d(b_iod), .ir_write(b_irw), .pc_write(b_pcw),
      .pc_src(b_pcs), .alu_src_a(b_sa), .alu_src_b(b_sb),
      .alu_op(b_op), .reg_write(b_rw), .mem_to_reg(b_m2r),
      .state(b_state), .retire(b_ret), .instret(b_instret),
      .mem_err(b_err), .illegal_trap(b_trap)
   );

   function automatic logic [14:0] mk(
      input logic req, we, iod, irw, pcw, pcs,
      input logic [1:0] sa, sb_, op,
      input logic rw, m2r, ret);
      return {req, we, iod, irw, pcw, pcs, sa, sb_, op, rw, m2r, ret};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One cycle: drive mem_ready, check state/controls, score retires.
   task automatic cyc(input logic [2:0] st, input logic rdy,
                      input logic [14:0] ctl, input string tag);
      logic [3:0] e;
      mem_ready = rdy;
      @(negedge clk);
      chk({tag, ".state"}, 32'(a_state), 32'(st));
      chk({tag, ".ctl"}, 32'(a_ctl), 32'(ctl));
      if (a_ret) begin
         chk({tag, ".sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
         e = (sb.size() != 0) ? sb.pop_front() : 4'hx;
         @(posedge clk); #1;
         chk({tag, ".instret"}, 32'(a_instret), 32'(e));
      end else begin
         @(posedge clk); #1;
      end
   endtask

   task automatic do_reset(input int n);
      reset = 1'b0;
      mem_ready = 1'b0;
      repeat (n) begin
         @(negedge clk);
         chk("rst.ctl_a", 32'(a_ctl), 32'd0);
         chk("rst.ctl_b", 32'(b_ctl), 32'd0);
         @(posedge clk); #1;
      end
      reset = 1'b1;
      exp_cnt = 4'd0;
      sb.delete();
      chk("rst.state", 32'(a_state), 32'd0);
      chk("rst.instret", 32'(a_instret), 32'd0);
      chk("rst.mem_err", 32'(a_err), 32'd0);
      chk("rst.trap", 32'(a_trap), 32'd0);
      chk("rst.state_t", 32'(b_state), 32'd0);
      chk("rst.mem_err_t", 32'(b_err), 32'd0);
   endtask

   task automatic run_instr(input logic [6:0] op, input logic z,
                            input int fs, input int ms);
      logic lw, swi;
      opcode = op;
      zero = z;
      lw = (op == OPC_LW);
      swi = (op == OPC_SW);
`ifdef ILLEGAL_TRAP_EN
      if (op != OPC_ILL) begin
         exp_cnt = exp_cnt + 4'd1;
         sb.push_back(exp_cnt);
      end
`else
      exp_cnt = exp_cnt + 4'd1;
      sb.push_back(exp_cnt);
`endif
      repeat (fs)
         cyc(3'd0, 1'b0, mk(1,0,0,0,0,0,A_PC,B_4,OP_ADD,0,0,0), "fetch_wait");
      cyc(3'd0, 1'b1, mk(1,0,0,1,1,0,A_PC,B_4,OP_ADD,0,0,0), "fetch");
      if (op == OPC_ILL) begin
`ifdef ILLEGAL_TRAP_EN
         cyc(3'd1, 1'b0, mk(0,0,0,0,0,0,A_OLD,B_IMM,OP_ADD,0,0,0), "dec_ill");
         @(negedge clk);
         chk("ill.state", 32'(a_state), 32'd5);
         chk("ill.trap", 32'(a_trap), 32'd1);
         chk("ill.mem_err", 32'(a_err), 32'd0);
         chk("ill.instret", 32'(a_instret), 32'(exp_cnt));
         chk("ill.ctl", 32'(a_ctl), 32'd0);
         @(posedge clk); #1;
`else
         cyc(3'd1, 1'b0, mk(0,0,0,0,0,0,A_OLD,B_IMM,OP_ADD,0,0,1), "dec_ill");
         @(negedge clk);
         chk("ill.state", 32'(a_state), 32'd0);
         chk("ill.trap", 32'(a_trap), 32'd0);
         @(posedge clk); #1;
`endif
         return;
      end
      cyc(3'd1, 1'b0, mk(0,0,0,0,0,0,A_OLD,B_IMM,OP_ADD,0,0,0), "decode");
      case (op)
         OPC_R:
            cyc(3'd2, 1'b0, mk(0,0,0,0,0,0,A_RS1,B_RS2,OP_FN,0,0,0), "ex_r");
         OPC_I:
            cyc(3'd2, 1'b0, mk(0,0,0,0,0,0,A_RS1,B_IMM,OP_FN,0,0,0), "ex_i");
         OPC_BEQ:
            cyc(3'd2, 1'b0, mk(0,0,0,0,z,1,A_RS1,B_RS2,OP_SUB,0,0,1), "ex_beq");
         default:
            cyc(3'd2, 1'b0, mk(0,0,0,0,0,0,A_RS1,B_IMM,OP_ADD,0,0,0), "ex_mem");
      endcase
      if (lw || swi) begin
         repeat (ms)
            cyc(3'd3, 1'b0, mk(1,swi,1,0,0,0,A_PC,B_RS2,OP_ADD,0,0,0), "mem_wait");
         cyc(3'd3, 1'b1, mk(1,swi,1,0,0,0,A_PC,B_RS2,OP_ADD,0,0,swi), "mem");
      end
      if (!swi && op != OPC_BEQ)
         cyc(3'd4, 1'b0, mk(0,0,0,0,0,0,A_PC,B_RS2,OP_ADD,1,lw,1), "wb");
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      opcode = OPC_R;
      zero = 1'b0;
      mem_ready = 1'b1;
      exp_cnt = 4'd0;
      @(posedge clk); #1;
      do_reset(2);

      run_instr(OPC_R, 1'b0, 0, 0);
      run_instr(OPC_I, 1'b0, 0, 0);
      run_instr(OPC_LW, 1'b0, 2, 3);
      run_instr(OPC_SW, 1'b0, 0, 0);
      run_instr(OPC_BEQ, 1'b1, 0, 0);
      run_instr(OPC_BEQ, 1'b0, 0, 0);
      run_instr(OPC_R, 1'b0, 1, 0);
      run_instr(OPC_ILL, 1'b0, 0, 0);
      chk("sb.drained", 32'(sb.size()), 32'd0);

      // Timeout: the WAIT_LIMIT=3 copy errors, the default copy keeps waiting.
      do_reset(1);
      opcode = OPC_R;
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("to.stall_state", 32'(b_state), 32'd0);
         chk("to.stall_req", 32'(b_req), 32'd1);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("to.state", 32'(b_state), 32'd5);
      chk("to.mem_err", 32'(b_err), 32'd1);
      chk("to.ctl", 32'(b_ctl), 32'd0);
      chk("to.other_state", 32'(a_state), 32'd0);
      chk("to.other_err", 32'(a_err), 32'd0);
      @(posedge clk); #1;
      mem_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("to.stuck", 32'(b_state), 32'd5);
         @(posedge clk); #1;
      end
      do_reset(1);

      // Wrap: 16 stores bring the 4-bit count back to 0.
      for (int i = 0; i < 16; i++) run_instr(OPC_SW, 1'b0, 0, 0);
      chk("wrap.instret", 32'(a_instret), 32'd0);
      opcode = OPC_SW;
      cyc(3'd0, 1'b1, mk(1,0,0,1,1,0,A_PC,B_4,OP_ADD,0,0,0), "w17_fetch");
      cyc(3'd1, 1'b0, mk(0,0,0,0,0,0,A_OLD,B_IMM,OP_ADD,0,0,0), "w17_dec");
      cyc(3'd2, 1'b0, mk(0,0,0,0,0,0,A_RS1,B_IMM,OP_ADD,0,0,0), "w17_ex");
      reset = 1'b0;
      mem_ready = 1'b1;
      @(negedge clk);
      chk("w17.mem_state", 32'(a_state), 32'd3);
      chk("w17.mem_ctl", 32'(a_ctl), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      mem_ready = 1'b0;
      chk("w17.state", 32'(a_state), 32'd0);
      chk("w17.instret", 32'(a_instret), 32'd0);
      @(negedge clk);
      chk("w17.no_we", 32'(a_we), 32'd0);
      chk("w17.fetch_ctl", 32'(a_ctl),
          32'(mk(1,0,0,0,0,0,A_PC,B_4,OP_ADD,0,0,0)));
      @(posedge clk); #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
